// File: rtl/mdio_lite_ctrl_if.sv
// Xillybus-lite user register port between the host side and the MDIO controller.
interface mdio_lite_ctrl_if;
   logic [31:0] user_addr;
   logic        user_wren;
   logic [3:0]  user_wstrb;
   logic [31:0] user_wr_data;
   logic        user_rden;
   logic [31:0] user_rd_data;
   logic        user_irq;

   modport master (
      output user_addr, user_wren, user_wstrb, user_wr_data, user_rden,
      input  user_rd_data, user_irq
   );

   modport slave (
      input  user_addr, user_wren, user_wstrb, user_wr_data, user_rden,
      output user_rd_data, user_irq
   );
endinterface

// File: rtl/mdio_lite_ctrl.sv
// Clause 22 MDIO management master behind a Xillybus-lite register window.
// Sequences 64-bit frames on MDC/MDIO and flags completion via DONE and user_irq.
module mdio_lite_ctrl #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0100,
   parameter logic [7:0]  DIV_DEFAULT = 8'd24
) (
   input  logic            bus_clk,
   input  logic            bus_rst_n,
   mdio_lite_ctrl_if.slave user,
   output logic            mdio_mdc,
   output logic            mdio_o,
   input  logic            mdio_i,
   output logic            mdio_t
);

   typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_TA, S_DATA, S_FIN} state_t;

   state_t      state, state_nxt;
   logic [26:0] cmd_q;
   logic [7:0]  div_q, div_sh;
   logic [7:0]  half_cnt;
   logic [5:0]  bit_cnt;
   logic [62:0] frame_sr;
   logic [15:0] rdata_sr, rdata_q;
   logic        rd_op;
   logic        done_q, ovr_q, irq_en_q;
   logic [31:0] rd_mux, rd_data_p1;

   logic        hit, busy, active, half_zero, mdc_fall;
   logic [1:0]  reg_sel;
   logic        cmd_wr, stat_wr, div_wr, start, done_set, ovr_set;
   logic [31:0] cmd_merged;
   logic        unused_bits;

   function automatic logic [31:0] merge_be(input logic [31:0] cur, input logic [31:0] wd,
                                            input logic [3:0] be);
      logic [31:0] r;
      r = cur;
      for (int i = 0; i < 4; i++)
         if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
      return r;
   endfunction

   // Bits 1..63 of the frame; bit 0 (first preamble 1) is driven straight at start.
   function automatic logic [62:0] build_frame(input logic [26:0] c);
      return {31'h7FFF_FFFF, 2'b01, (c[26] ? 2'b10 : 2'b01), c[25:21], c[20:16],
              (c[26] ? 18'h3_FFFF : {2'b10, c[15:0]})};
   endfunction

   assign hit        = (user.user_addr[31:4] == BASE_ADDR[31:4]);
   assign reg_sel    = user.user_addr[3:2];
   assign busy       = (state != S_IDLE);
   assign cmd_wr     = hit && user.user_wren && (reg_sel == 2'd0);
   assign stat_wr    = hit && user.user_wren && (reg_sel == 2'd1);
   assign div_wr     = hit && user.user_wren && (reg_sel == 2'd2);
   assign start      = cmd_wr && !busy && (user.user_wstrb == 4'hF);
   assign ovr_set    = cmd_wr && busy;
   assign done_set   = (state == S_FIN);
   assign active     = state inside {S_PRE, S_HDR, S_TA, S_DATA};
   assign half_zero  = (half_cnt == 8'd0);
   assign mdc_fall   = active && half_zero && mdio_mdc;
   assign cmd_merged = merge_be({5'd0, cmd_q}, user.user_wr_data, user.user_wstrb);
   assign unused_bits = ^{user.user_addr[1:0], cmd_merged[31:27]};

   always_ff @(posedge bus_clk or negedge bus_rst_n) begin
      if (!bus_rst_n) state <= S_IDLE;
      else            state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_PRE;
         S_PRE:   if (mdc_fall && bit_cnt == 6'd31) state_nxt = S_HDR;
         S_HDR:   if (mdc_fall && bit_cnt == 6'd45) state_nxt = S_TA;
         S_TA:    if (mdc_fall && bit_cnt == 6'd47) state_nxt = S_DATA;
         S_DATA:  if (mdc_fall && bit_cnt == 6'd63) state_nxt = S_FIN;
         S_FIN:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Bit engine: MDC toggles every DIV+1 clocks; a new bit starts on each falling edge.
   always_ff @(posedge bus_clk or negedge bus_rst_n) begin
      if (!bus_rst_n) begin
         mdio_mdc <= 1'b0;
         mdio_o   <= 1'b1;
         mdio_t   <= 1'b1;
         half_cnt <= 8'd0;
         bit_cnt  <= 6'd0;
         div_sh   <= DIV_DEFAULT;
         frame_sr <= '1;
         rd_op    <= 1'b0;
         rdata_sr <= 16'd0;
      end else if (start) begin
         mdio_mdc <= 1'b0;
         mdio_o   <= 1'b1;
         mdio_t   <= 1'b0;
         half_cnt <= div_q;
         div_sh   <= div_q;
         bit_cnt  <= 6'd0;
         frame_sr <= build_frame(user.user_wr_data[26:0]);
         rd_op    <= user.user_wr_data[26];
      end else if (active) begin
         if (half_zero) begin
            half_cnt <= div_sh;
            mdio_mdc <= !mdio_mdc;
            if (mdio_mdc) begin
               bit_cnt  <= bit_cnt + 6'd1;
               frame_sr <= {frame_sr[61:0], 1'b1};
               if (bit_cnt == 6'd63) begin
                  mdio_o <= 1'b1;
                  mdio_t <= 1'b1;
               end else begin
                  mdio_o <= frame_sr[62];
                  mdio_t <= rd_op && (bit_cnt >= 6'd45);
               end
            end else if (rd_op && bit_cnt >= 6'd48) begin
               rdata_sr <= {rdata_sr[14:0], mdio_i};
            end
         end else begin
            half_cnt <= half_cnt - 8'd1;
         end
      end else begin
         mdio_mdc <= 1'b0;
         mdio_o   <= 1'b1;
         mdio_t   <= 1'b1;
      end
   end

   // Register file; DONE/OVR setting beats a simultaneous write-one-to-clear.
   always_ff @(posedge bus_clk or negedge bus_rst_n) begin
      if (!bus_rst_n) begin
         cmd_q    <= 27'd0;
         div_q    <= DIV_DEFAULT;
         done_q   <= 1'b0;
         ovr_q    <= 1'b0;
         irq_en_q <= 1'b0;
         rdata_q  <= 16'd0;
      end else begin
         if (cmd_wr && !busy)                 cmd_q    <= cmd_merged[26:0];
         if (div_wr && user.user_wstrb[0])    div_q    <= user.user_wr_data[7:0];
         if (stat_wr)                         irq_en_q <= user.user_wr_data[3];
         if (done_set)                        done_q   <= 1'b1;
         else if (stat_wr && user.user_wr_data[1]) done_q <= 1'b0;
         if (ovr_set)                         ovr_q    <= 1'b1;
         else if (stat_wr && user.user_wr_data[2]) ovr_q  <= 1'b0;
         if (done_set && rd_op)               rdata_q  <= rdata_sr;
      end
   end

   always_comb begin
      rd_mux = 32'd0;
      if (hit) begin
         case (reg_sel)
            2'd0:    rd_mux = {5'd0, cmd_q};
            2'd1:    rd_mux = {rdata_q, 12'd0, irq_en_q, ovr_q, done_q, busy};
            2'd2:    rd_mux = {24'd0, div_q};
            default: rd_mux = 32'd0;
         endcase
      end
   end

   // Read stage: data valid the cycle after user_rden.
   always_ff @(posedge bus_clk or negedge bus_rst_n) begin
      if (!bus_rst_n)          rd_data_p1 <= 32'd0;
      else if (user.user_rden) rd_data_p1 <= rd_mux;
   end

   assign user.user_rd_data = rd_data_p1;
   assign user.user_irq     = done_q & irq_en_q;

endmodule
